// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB result type and sizing constants
package tomasula_types;

  localparam int NUM_FU = 8;
  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(NUM_FU);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

  // Round-robin pointer moves to the slot just past the winner.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_FU - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rtl/cdb_arbiter_rr_arbiter.sv - combinational round-robin picker starting at ptr
module rr_arbiter #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  int j;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        gnt_idx  = W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - buffers one result per functional unit and broadcasts one per cycle on the CDB
module cdb_arbiter
  import tomasula_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NUM_FU-1:0] fu_valid,
  input  cdb_t [NUM_FU-1:0] fu_res,
  output logic [NUM_FU-1:0] fu_ready,
  output logic              cdb_valid,
  output cdb_t              cdb_out,
  output logic [IDX_W-1:0]  cdb_src
);

  logic [NUM_FU-1:0] hold_v;
  cdb_t              hold [NUM_FU];
  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] accept;
  logic [IDX_W-1:0]  gnt_idx;
  logic              any;

  // Flush masks the request vector so nothing is granted in the squash cycle.
  assign req      = flush ? '0 : hold_v;
  assign fu_ready = flush ? '0 : (~hold_v | grant);
  assign accept   = fu_valid & fu_ready;

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v    <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_out   <= '0;
      cdb_src   <= '0;
    end else begin
      hold_v    <= flush ? '0 : (accept | (hold_v & ~grant));
      cdb_valid <= any;
      if (any) begin
        cdb_out <= hold[gnt_idx];
        cdb_src <= gnt_idx;
        rr_ptr  <= next_ptr(gnt_idx);
      end
    end
  end

  // Payload needs no reset; hold_v qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i]) hold[i] <= fu_res[i];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
  import tomasula_types::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [NUM_FU-1:0] fu_valid = '0;
  cdb_t [NUM_FU-1:0] fu_res = '0;
  logic [NUM_FU-1:0] fu_ready;
  logic              cdb_valid;
  cdb_t              cdb_out;
  logic [IDX_W-1:0]  cdb_src;

  typedef struct {
    int               cyc;
    logic [IDX_W-1:0] src;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   c;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_res    (fu_res),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_out   (cdb_out),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int p, input logic [TAG_W-1:0] tag, input logic [31:0] data,
                         input int when, input bit expect_it);
    exp_t e;
    fu_valid[p]     = 1'b1;
    fu_res[p].tag   = tag;
    fu_res[p].data  = data;
    if (expect_it) begin
      e.cyc  = when;
      e.src  = IDX_W'(p);
      e.tag  = tag;
      e.data = data;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cdb_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_bcast", 64'(cdb_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("bcast_cyc", 64'(cyc), 64'(e.cyc));
        check_eq("bcast_src", 64'(cdb_src), 64'(e.src));
        check_eq("bcast_tag", 64'(cdb_out.tag), 64'(e.tag));
        check_eq("bcast_data", 64'(cdb_out.data), 64'(e.data));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(cdb_valid), 64'd0);
    check_eq("rst_src", 64'(cdb_src), 64'd0);
    check_eq("rst_out", 64'(cdb_out), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_ready", 64'(fu_ready), 64'hFF);
    tick();

    // all eight ports at once from rr_ptr=0: src 0..7 back to back
    c = cyc;
    for (int p = 0; p < NUM_FU; p++) present(p, TAG_W'(p), 32'hC0DE_0000 + p, c + 2 + p, 1'b1);
    tick();
    fu_valid = '0;
    repeat (10) tick();

    // single result, two edges to the bus, one cycle wide
    c = cyc;
    present(3, 3'd5, 32'hDEAD_BEEF, c + 2, 1'b1);
    tick();
    fu_valid = '0;
    @(negedge clk);
    check_eq("single_no_bypass", 64'(cdb_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("single_one_cycle", 64'(cdb_valid), 64'd0);
    repeat (3) tick();

    // move pointer to 7
    c = cyc;
    present(6, 3'd1, 32'h0000_0606, c + 2, 1'b1);
    tick();
    fu_valid = '0;
    repeat (4) tick();

    // wrap: 7 then 0
    c = cyc;
    present(7, 3'd2, 32'h0000_0707, c + 2, 1'b1);
    present(0, 3'd3, 32'h0000_0A00, c + 3, 1'b1);
    tick();
    fu_valid = '0;
    repeat (4) tick();

    // pointer now 1: port 1 beats port 0
    c = cyc;
    present(1, 3'd4, 32'h0000_0B01, c + 2, 1'b1);
    present(0, 3'd6, 32'h0000_0B00, c + 3, 1'b1);
    tick();
    fu_valid = '0;
    repeat (4) tick();

    // mid-run reset drops everything in flight
    c = cyc;
    present(4, 3'd0, 32'h1111_0004, 0, 1'b0);
    present(5, 3'd1, 32'h1111_0005, 0, 1'b0);
    present(6, 3'd2, 32'h1111_0006, 0, 1'b0);
    tick();
    fu_valid = '0;
    tick();
    check_eq("pre_rst_valid", 64'(cdb_valid), 64'd1);
    check_eq("pre_rst_src", 64'(cdb_src), 64'd4);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", 64'(cdb_valid), 64'd0);
    check_eq("rst_mid_src", 64'(cdb_src), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_mid_ready", 64'(fu_ready), 64'hFF);
    repeat (5) tick();

    // back-pressure on port 2 while 0 and 1 win
    c = cyc;
    present(0, 3'd0, 32'h2222_0000, c + 2, 1'b1);
    present(1, 3'd1, 32'h2222_0001, c + 3, 1'b1);
    present(2, 3'd2, 32'h2222_0002, c + 4, 1'b1);
    tick();
    fu_valid = '0;
    present(2, 3'd7, 32'h2222_0BBB, c + 5, 1'b1);
    @(negedge clk);
    check_eq("bp_ready_wait1", 64'(fu_ready[2]), 64'd0);
    tick();
    @(negedge clk);
    check_eq("bp_ready_wait2", 64'(fu_ready[2]), 64'd0);
    tick();
    @(negedge clk);
    check_eq("bp_ready_grant", 64'(fu_ready[2]), 64'd1);
    tick();
    fu_valid = '0;
    repeat (4) tick();

    // flush with four held and one on the bus
    c = cyc;
    for (int p = 0; p < 5; p++) present(p, TAG_W'(p), 32'h3333_0000 + p, c + 2, p == 3);
    tick();
    fu_valid = '0;
    tick();
    flush = 1'b1;
    present(5, 3'd5, 32'h3333_0005, 0, 1'b0);
    @(negedge clk);
    check_eq("flush_ready", 64'(fu_ready), 64'd0);
    check_eq("flush_bus_busy", 64'(cdb_valid), 64'd1);
    tick();
    flush = 1'b0;
    fu_valid = '0;
    @(negedge clk);
    check_eq("flush_valid", 64'(cdb_valid), 64'd0);
    repeat (10) tick();

    c = cyc;
    present(6, 3'd6, 32'h4444_0006, c + 2, 1'b1);
    tick();
    fu_valid = '0;
    repeat (4) tick();

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
